// File: rtl/eq_spi_tx.sv
// SPI controller-side transmitter: sends one WIDTH-bit word per frame, MSB first.
// The receiver samples sdo on the sck rising edge while ce (active high) frames the word.
// Optional macro EQ_SPI_TX_ABORT_EN adds the abort input and the aborted output.
// Ports:
//   clk, reset      : system clock and synchronous active-high reset
//   tx_data         : word to send (bit WIDTH-1 goes out first)
//   tx_valid        : source has a word on tx_data
//   tx_ready        : transmitter idle; the word is taken when tx_valid & tx_ready
//   sck, sdo, ce    : SPI pins (sck idles low)
//   done            : one-clk pulse at the end of a normal frame
//   abort, aborted  : (macro only) cancel a frame / one-clk pulse confirming it
module eq_spi_tx #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sck,
    output logic             sdo,
    output logic             ce,
    output logic             done
`ifdef EQ_SPI_TX_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_TOP = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ready_d, sck_d, sdo_d, ce_d, done_d;
    logic             phase_end;
`ifdef EQ_SPI_TX_ABORT_EN
    logic             aborted_d;
`endif

    assign phase_end = (div_q == DIV_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_ready <= 1'b1;
            sck      <= 1'b0;
            sdo      <= 1'b0;
            ce       <= 1'b0;
            done     <= 1'b0;
`ifdef EQ_SPI_TX_ABORT_EN
            aborted  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_ready <= ready_d;
            sck      <= sck_d;
            sdo      <= sdo_d;
            ce       <= ce_d;
            done     <= done_d;
`ifdef EQ_SPI_TX_ABORT_EN
            aborted  <= aborted_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = '0;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ready_d = tx_ready;
        sck_d   = sck;
        sdo_d   = sdo;
        ce_d    = ce;
        done_d  = 1'b0;
`ifdef EQ_SPI_TX_ABORT_EN
        aborted_d = 1'b0;
`endif
        // Divider runs through every busy phase and wraps at the phase end.
        if (state_q != IDLE && !phase_end) begin
            div_d = div_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    shreg_d = tx_data;
                    sdo_d   = tx_data[WIDTH-1];
                    ce_d    = 1'b1;
                    ready_d = 1'b0;
                    bit_d   = BIT_TOP;
                    state_d = SETUP;
                end
            end
            SETUP, LOW: begin
                if (phase_end) begin
                    sck_d   = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    sck_d = 1'b0;
                    if (bit_q == '0) begin
                        state_d = HOLD;
                    end else begin
                        // Rotate so the next bit sits at the top; sdo only
                        // moves on the falling edge.
                        sdo_d   = shreg_q[WIDTH-2];
                        shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
                        bit_d   = bit_q - 1'b1;
                        state_d = LOW;
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    ce_d    = 1'b0;
                    sdo_d   = 1'b0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef EQ_SPI_TX_ABORT_EN
        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            div_d     = '0;
            ce_d      = 1'b0;
            sck_d     = 1'b0;
            sdo_d     = 1'b0;
            ready_d   = 1'b1;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_eq_spi_tx.sv
// Self-checking bench for eq_spi_tx: directed and random words are checked
// against an SPI receiver model (shift on sck rise while ce is high).
module tb_eq_spi_tx;

    localparam int W    = 32;
    localparam int DIV  = 4;
    localparam int FLEN = DIV * (2 * W + 1);

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         tx_valid = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_ready, sck, sdo, ce, done;
`ifdef EQ_SPI_TX_ABORT_EN
    logic         abort = 1'b0;
    logic         aborted;
`endif

    eq_spi_tx #(.WIDTH(W), .CLK_DIV(DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .sck      (sck),
        .sdo      (sdo),
        .ce       (ce),
        .done     (done)
`ifdef EQ_SPI_TX_ABORT_EN
        ,
        .abort    (abort),
        .aborted  (aborted)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] word;
        int           bits;
        int           len;
        logic         done_al;
    } frame_t;

    frame_t       rx_q[$];
    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    int           cur_bits = 0;
    int           cur_len = 0;
    int           low_len = 0;
    int           last_gap = 0;
    logic [W-1:0] cur_word = '0;
    logic         prev_ce = 1'b0;
    logic         prev_sck = 1'b0;

    // Receiver model, sampled on the falling clk edge.
    initial begin
        forever begin
            frame_t f;
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (ce === 1'b1) begin
                if (!prev_ce) begin
                    last_gap = low_len;
                    cur_len  = 0;
                    cur_bits = 0;
                    cur_word = '0;
                end
                cur_len++;
                if (sck === 1'b1 && !prev_sck) begin
                    cur_word = {cur_word[W-2:0], sdo};
                    cur_bits++;
                end
            end else begin
                if (prev_ce) begin
                    f.word    = cur_word;
                    f.bits    = cur_bits;
                    f.len     = cur_len;
                    f.done_al = done;
                    rx_q.push_back(f);
                    low_len = 0;
                end
                low_len++;
            end
            prev_ce  = (ce === 1'b1);
            prev_sck = (sck === 1'b1);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {59'd0, tx_ready, ce, sck, sdo, done}, 64'b10000);
    endtask

    task automatic send(input logic [W-1:0] w);
        int n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", tx_ready, 1);
        tx_data  = w;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = $urandom;
    endtask

    task automatic expect_frame(input string tag, input logic [W-1:0] w);
        int n = 0;
        frame_t f;
        while (rx_q.size() == 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_wait"}, rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
            f = rx_q.pop_front();
            chk({tag, "_word"}, f.word, w);
            chk({tag, "_bits"}, f.bits, W);
            chk({tag, "_celen"}, f.len, FLEN);
            chk({tag, "_done_al"}, f.done_al, 1);
        end
    endtask

    task automatic wait_bits(input string tag, input int nb);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (cur_bits != nb && n < 2000);
        chk(tag, cur_bits, nb);
    endtask

    initial begin
        int dc;
        int n;
        logic [W-1:0] w;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_idle("reset");
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_idle("idle");
        end

        dc = done_cnt;
        send(32'hA5C3_0F81);
        chk("single_busy", tx_ready, 0);
        expect_frame("single", 32'hA5C3_0F81);
        chk("single_done_cnt", done_cnt, dc + 1);

        send(32'h0000_0001);
        tx_data  = 32'hFFFF_FFFE;
        tx_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 2000);
        chk("b2b_done", done, 1);
        chk("b2b_ready", tx_ready, 1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("b2b_ce", ce, 1);
        @(posedge clk);
        chk("b2b_gap", last_gap, 1);
        expect_frame("b2b_a", 32'h0000_0001);
        expect_frame("b2b_b", 32'hFFFF_FFFE);

        send(32'hDEAD_BEEF);
        repeat (10) @(negedge clk);
        chk("busy_ready", tx_ready, 0);
        tx_data  = 32'h1234_5678;
        tx_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("busy_ready2", tx_ready, 0);
        tx_valid = 1'b0;
        expect_frame("busy", 32'hDEAD_BEEF);
        repeat (300) @(posedge clk);
        chk("busy_no_extra", rx_q.size(), 0);
        chk("busy_ce_low", ce, 0);

        send($urandom);
        wait_bits("rst_bits", 12);
        @(negedge clk);
        dc = done_cnt;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("rst_mid");
        reset = 1'b0;
        repeat (20) @(posedge clk);
        chk("rst_no_done", done_cnt, dc);
        rx_q.delete();
        w = $urandom;
        send(w);
        expect_frame("rst_after", w);

`ifdef EQ_SPI_TX_ABORT_EN
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_idle", {aborted, tx_ready}, 2'b01);
        send($urandom);
        wait_bits("abort_bits", 20);
        @(negedge clk);
        dc = done_cnt;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_out", {tx_ready, ce, sck, sdo, done, aborted}, 6'b100001);
        @(posedge clk);
        #1;
        chk("abort_pulse", aborted, 0);
        repeat (20) @(posedge clk);
        chk("abort_no_done", done_cnt, dc);
        rx_q.delete();
        send(32'h0F0F_0F0F);
        expect_frame("abort_after", 32'h0F0F_0F0F);
`endif

        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            repeat ($urandom_range(0, 5)) @(posedge clk);
            send(w);
            expect_frame("rand", w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eq_spi_tx.md
Name: eq_spi_tx

Overview:
- SPI controller-side transmitter that sends one WIDTH-bit equalizer word per transaction.
- Targets the FPGA equalizer-coefficient SPI receiver: ce active-high frames the word, data is sampled on sck rising edge, MSB first.
- Sits between a word source (test pattern, register bank, or soft core) and the SPI pins.
- Generates sck, sdo and ce from the single system clock using a programmable half-period divider.

Parameters:
- WIDTH, 32, bits per transaction; must be >= 2.
- CLK_DIV, 4, clk cycles per sck half-period; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  WIDTH  word to send; bit WIDTH-1 goes out first.
- tx_valid  input  1  source has a word on tx_data.
- tx_ready  output  1  transmitter idle; a word is accepted when tx_valid & tx_ready.
- sck  output  1  SPI clock; idles low.
- sdo  output  1  serial data to the receiver's sdi.
- ce  output  1  active-high frame enable; high for the whole transaction.
- done  output  1  one-clk pulse when a transaction finishes normally.

Behaviour:
- Reset is synchronous and active-high. On the first clk edge with reset high: state=IDLE, tx_ready=1, sck=0, sdo=0, ce=0, done=0, divider=0, bit count=0, shift register=0. This applies at any point, including mid-transaction.
- All outputs are registered.
- The divider counts 0..CLK_DIV-1 in every non-IDLE state. A phase ends on the cycle where divider==CLK_DIV-1; the divider then clears.
- IDLE:
  - tx_ready=1, ce=0, sck=0.
  - On tx_valid & tx_ready: shreg<=tx_data, sdo<=tx_data[WIDTH-1], ce<=1, tx_ready<=0, bitcnt<=WIDTH-1, go to SETUP.
- SETUP: sck=0 for CLK_DIV cycles; at phase end sck<=1, go to HIGH.
- HIGH: sck=1 for CLK_DIV cycles. At phase end sck<=0, then:
  - if bitcnt==0, go to HOLD;
  - otherwise sdo<=next lower bit, bitcnt<=bitcnt-1, go to LOW.
  - sdo therefore changes only on sck falling edges and is stable at every rising edge.
- LOW: sck=0 for CLK_DIV cycles; at phase end sck<=1, go to HIGH.
- HOLD:
  - sck=0 for CLK_DIV cycles.
  - At phase end: ce<=0, sdo<=0, done<=1 for exactly one cycle, go to IDLE.
  - tx_ready rises together with done.
- Frame timing:
  - ce is high for exactly CLK_DIV*(2*WIDTH+1) clk cycles.
  - Exactly WIDTH sck rising edges occur per frame.
  - Default parameters give 260 cycles.
- Back-to-back transfers: a word presented while done=1 is accepted that same cycle. ce is therefore low for at least 1 clk cycle between frames, which the receiver's 32-bit shift reset requires.
- tx_valid while busy is ignored; tx_data is not sampled after acceptance.
- tx_data may change freely while busy.
- If reset is asserted together with an accept, reset wins: no frame starts.

Optional Feature:
- Macro: EQ_SPI_TX_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 in any non-IDLE state: next edge forces ce=0, sck=0, sdo=0, aborted=1 for one cycle, done stays 0, state=IDLE, tx_ready=1.
  - abort in IDLE has no effect.
  - abort together with reset: reset wins and aborted stays 0.
- Undefined: neither port exists, and behaviour is exactly as above.

Test Plan:
- Reset then idle (reset high 3 cycles, then low) -> tx_ready=1, ce=0, sck=0, sdo=0, done=0 at every cycle.
- Single word (WIDTH=32, CLK_DIV=4, tx_data=32'hA5C3_0F81, 1-cycle tx_valid) ->
  - 32 sck rising edges;
  - bits sampled at each rising edge, MSB first, reassemble to 32'hA5C3_0F81;
  - ce high 260 cycles;
  - one done pulse, cycle-aligned with ce falling.
- Back-to-back (32'h0000_0001 then 32'hFFFF_FFFE, second tx_valid held high) ->
  - second word accepted on the done cycle;
  - ce low exactly 1 cycle between frames;
  - both words are received intact by a receiver model that shifts on posedge sck while ce is high.
- Busy ignore (tx_valid with 32'h1234_5678 asserted 10 cycles into a 32'hDEAD_BEEF frame) -> tx_ready=0 during the frame; output is 32'hDEAD_BEEF only.
- Reset mid-frame (reset at sck edge 12) -> next clk: ce=0, sck=0, sdo=0, tx_ready=1, done never pulses; a new word then transfers correctly.
- EQ_SPI_TX_ABORT_EN defined, abort at sck edge 20 -> next clk: ce=0, aborted=1 for 1 cycle, done=0; a subsequent word 32'h0F0F_0F0F transfers correctly.
